mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port instruction/data memory between the IF stage (fetch) and the MEM stage (load/store).
//  Grants one access at a time and tracks the fixed memory latency.
//  Returns read data or a write ack to the owning requester, and drives per-stage stall requests to pipeline control.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  MEM_LAT     2   cycles from mem_req_o to mem_rdata_i valid; legal range 1..15
//  STARVE_MAX  4   consecutive contested D grants before IF is forced (only with ARB_STARVE_GUARD_EN)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  if_req_i     in   1       fetch request; held with if_addr_i until if_rvalid_o
//  if_addr_i    in   ADDR_W  fetch address
//  if_gnt_o     out  1       fetch granted (1-cycle pulse)
//  if_rvalid_o  out  1       fetch data valid (1-cycle pulse)
//  if_rdata_o   out  DATA_W  instruction word
//  d_req_i      in   1       data request; held with d_we_i, d_addr_i, d_wdata_i until d_rvalid_o
//  d_we_i       in   1       1 = store (ctrl_t.MemRW), 0 = load
//  d_addr_i     in   ADDR_W  data address (alu_out)
//  d_wdata_i    in   DATA_W  store data (rs2_data)
//  d_gnt_o      out  1       data granted (1-cycle pulse)
//  d_rvalid_o   out  1       load data valid / store ack (1-cycle pulse)
//  d_rdata_o    out  DATA_W  load data
//  mem_req_o    out  1       memory access strobe
//  mem_we_o     out  1       memory write enable
//  mem_addr_o   out  ADDR_W  memory address
//  mem_wdata_o  out  DATA_W  memory write data
//  mem_rdata_i  in   DATA_W  memory read data; valid exactly MEM_LAT cycles after mem_req_o
//  stall_if_o   out  1       = if_req_i & ~if_rvalid_o
//  stall_mem_o  out  1       = d_req_i & ~d_rvalid_o
//  busy_o       out  1       state != ARB_IDLE
// BEHAVIOUR
//  Reset
//   - Async reset forces state ARB_IDLE and owner OWN_IF; lat_cnt and starve_cnt go to 0.
//   - All gnt/rvalid/mem_* outputs, rdata outputs, and busy_o are 0.
//   - A response in flight at reset is discarded: no rvalid after reset release.
//  FSM states: ARB_IDLE, ARB_WAIT
//  ARB_IDLE
//   - If any req is high: grant combinationally in the same cycle T.
//   - Drive mem_* from the winner, latch owner, set lat_cnt = MEM_LAT-1, and go to ARB_WAIT.
//   - With no req: all outputs 0.
//  ARB_WAIT
//   - Requests are ignored. lat_cnt decrements each cycle.
//   - At T+MEM_LAT, the owner's rvalid = 1 and rdata = mem_rdata_i (combinational pass-through); next state is ARB_IDLE.
//   - The next grant is possible at T+MEM_LAT+1, so throughput is 1 access per MEM_LAT+1 cycles.
//  Priority
//   - D beats IF on contention, because the MEM stage holds the older instruction.
//  Stores
//   - Issued with mem_we_o=1. d_rvalid_o acts as the ack at T+MEM_LAT; d_rdata_o = 0 on that cycle.
//  Requester side
//   - A requester that drops req during ARB_WAIT (flush) still receives its rvalid pulse, which it ignores.
//   - The memory access is never cancelled.
//  Other outputs
//   - rdata outputs are 0 whenever their rvalid is 0.
//   - Non-owner gnt/rvalid are 0.
//  MEM_LAT=1
//   - ARB_WAIT lasts exactly 1 cycle. lat_cnt width is 4 bits.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined
//   - starve_cnt increments on every D grant made while if_req_i=1, and saturates at STARVE_MAX.
//   - When starve_cnt==STARVE_MAX and both requests are high, IF wins.
//   - starve_cnt clears on any IF grant.
//  ARB_STARVE_GUARD_EN undefined
//   - Fixed D priority. The starve_cnt logic is absent.
// STRUCTURE
//  - Add to rv32_pkg: typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t.
//  - Add to rv32_pkg: typedef enum logic {OWN_IF, OWN_D} arb_owner_t.
//  - Sub-module arb_starve_ctr (saturating counter plus force flag) is instantiated only under ARB_STARVE_GUARD_EN.
//  - All other logic stays flat in this module.
// TESTING (MEM_LAT=2, STARVE_MAX=2)
//  1. Hold rst=1 mid-cycle -> all outputs 0 immediately; busy_o=0.
//  2. if_req_i=1, if_addr_i=0x10 at T; mem_rdata_i=0x00500093 at T+2
//     -> if_gnt_o=1, mem_addr_o=0x10, mem_we_o=0 at T; stall_if_o=1 at T..T+1;
//        if_rvalid_o=1, if_rdata_o=0x00500093, stall_if_o=0 at T+2.
//  3. Load d_addr_i=0x100 and fetch 0x14 both at T -> d_gnt_o at T, d_rvalid_o at T+2;
//     if_gnt_o at T+3, if_rvalid_o at T+5.
//  4. Store d_addr_i=0x200, d_wdata_i=0xDEADBEEF at T -> mem_we_o=1, mem_wdata_o=0xDEADBEEF at T;
//     d_rvalid_o=1, d_rdata_o=0 at T+2.
//  5. d_req_i held for back-to-back accesses with if_req_i held -> grant order D, D, IF with the macro;
//     without the macro, IF is granted only after d_req_i drops.
//  6. Reset pulse at T+1 after a D grant at T -> no d_rvalid_o at T+2; a new grant is possible in the first cycle after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

  // Arbiter control states: waiting for a request, or tracking an access in flight.
  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;

  // Which pipeline stage owns the access currently in flight.
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

  // Latency counter width; holds MEM_LAT-1 for MEM_LAT up to 15.
  localparam int LAT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of contested D grants; raises force_if once IF has lost
// STARVE_MAX arbitrations in a row. Used only with ARB_STARVE_GUARD_EN.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic force_if
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  // Count D grants that beat a waiting fetch, clear on any IF grant, stick at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (clr) begin
      starve_cnt <= '0;
    end else if (inc && (starve_cnt != CNT_W'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign force_if = (starve_cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the IF (fetch) and MEM
// (load/store) stages. One access at a time, fixed MEM_LAT latency, D wins ties.
// Optional feature: define ARB_STARVE_GUARD_EN to force an IF grant after
// STARVE_MAX consecutive contested D grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_if_o,
  output logic              stall_mem_o,
  output logic              busy_o
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

  arb_state_t       state_q, state_d;
  arb_owner_t       owner_q, owner_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             we_q, we_d;
  logic             grant_d, grant_if;
  logic             force_if;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (grant_d & if_req_i),
    .clr      (grant_if),
    .force_if (force_if)
  );
`else
  // Fixed D priority: IF is never forced, so STARVE_MAX has no effect here.
  logic unused_starve_max;
  assign unused_starve_max = ^STARVE_MAX;
  assign force_if          = 1'b0;
`endif

  // Arbiter state, owner, store flag and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_IF;
      lat_cnt_q <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
      we_q      <= we_d;
    end
  end

  // Same-cycle grant in idle, then count down the latency and return the response to the owner.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    we_d        = we_q;
    grant_d     = 1'b0;
    grant_if    = 1'b0;
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_gnt_o     = 1'b0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      ARB_IDLE: begin
        if (!rst) begin
          if (d_req_i && !(force_if && if_req_i)) begin
            grant_d = 1'b1;
          end else if (if_req_i) begin
            grant_if = 1'b1;
          end
        end
        if (grant_d) begin
          d_gnt_o     = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = d_we_i;
          mem_addr_o  = d_addr_i;
          mem_wdata_o = d_wdata_i;
          owner_d     = OWN_D;
          we_d        = d_we_i;
          lat_cnt_d   = LAT_INIT;
          state_d     = ARB_WAIT;
        end else if (grant_if) begin
          if_gnt_o    = 1'b1;
          mem_req_o   = 1'b1;
          mem_addr_o  = if_addr_i;
          owner_d     = OWN_IF;
          we_d        = 1'b0;
          lat_cnt_d   = LAT_INIT;
          state_d     = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_q == '0) begin
          lat_cnt_d = '0;
          state_d   = ARB_IDLE;
          if (owner_q == OWN_D) begin
            d_rvalid_o = 1'b1;
            d_rdata_o  = we_q ? '0 : mem_rdata_i;
          end else begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign stall_if_o  = if_req_i & ~if_rvalid_o;
  assign stall_mem_o = d_req_i & ~d_rvalid_o;
  assign busy_o      = (state_q != ARB_IDLE);

endmodule
